// File: rtl/spi_int_ctrl.sv
// Interrupt flag/enable/mask/clear endpoint for the SPI slave; drives one registered irq line.
// Optional overflow flags per source are added when SPI_INT_OVF_EN is defined.
module spi_int_ctrl #(
  parameter int NUM_SRC  = 4,
  parameter int SRC_EDGE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src,
  input  logic [NUM_SRC-1:0] en,
  input  logic [NUM_SRC-1:0] msk,
  input  logic [NUM_SRC-1:0] clr,
`ifdef SPI_INT_OVF_EN
  output logic [NUM_SRC-1:0] ovf,
`endif
  output logic [NUM_SRC-1:0] fl,
  output logic               irq
);

  logic [NUM_SRC-1:0] src_dly_q;
  logic [NUM_SRC-1:0] fl_q, fl_d;
  logic               irq_q, irq_d;
  logic [NUM_SRC-1:0] evt;

  always_comb begin
    evt = '0;
    if (SRC_EDGE != 0) evt = src & ~src_dly_q & en;
    else               evt = src & en;
  end

  // A new event wins over a same-cycle clear so no event is lost.
  always_comb begin
    fl_d  = (fl_q & ~clr) | evt;
    irq_d = |(fl_q & ~msk);
  end

  // src_dly resets high so a source already asserted at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_dly_q <= '1;
      fl_q      <= '0;
      irq_q     <= 1'b0;
    end else begin
      src_dly_q <= src;
      fl_q      <= fl_d;
      irq_q     <= irq_d;
    end
  end

`ifdef SPI_INT_OVF_EN
  logic [NUM_SRC-1:0] ovf_q, ovf_d;

  // Clear dominates: an event coinciding with clr is absorbed by fl, not counted as lost.
  always_comb begin
    ovf_d = (ovf_q | (evt & fl_q)) & ~clr;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= '0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

  assign fl  = fl_q;
  assign irq = irq_q;

endmodule

// File: tb/tb_spi_int_ctrl.sv
// Directed self-checking bench for spi_int_ctrl (NUM_SRC=4, SRC_EDGE=1).
// Overflow checks are compiled in when SPI_INT_OVF_EN is defined.
module tb_spi_int_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] src, en, msk, clr;
  logic [3:0] fl;
  logic       irq;
`ifdef SPI_INT_OVF_EN
  logic [3:0] ovf;
`endif

  int n_chk;
  int n_fail;

  spi_int_ctrl #(.NUM_SRC(4), .SRC_EDGE(1)) dut (
    .clk (clk),
    .rst (rst),
    .src (src),
    .en  (en),
    .msk (msk),
    .clr (clr),
`ifdef SPI_INT_OVF_EN
    .ovf (ovf),
`endif
    .fl  (fl),
    .irq (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst = 1'b1; src = 4'b0001; en = 4'h0; msk = 4'h0; clr = 4'h0;
    tick(); tick();
    check("reset_fl", {28'd0, fl}, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);
`ifdef SPI_INT_OVF_EN
    check("reset_ovf", {28'd0, ovf}, 32'h0);
`endif

    // Source held high across reset release: no edge.
    rst = 1'b0; en = 4'hF;
    tick(); tick();
    check("no_edge_at_release_fl", {28'd0, fl}, 32'h0);
    check("no_edge_at_release_irq", {31'd0, irq}, 32'h0);

    src = 4'b0101;
    tick();
    check("edge2_fl", {28'd0, fl}, 32'h4);
    check("edge2_irq_lag", {31'd0, irq}, 32'h0);
    tick();
    check("edge2_irq", {31'd0, irq}, 32'h1);

    clr = 4'b0100;
    tick();
    check("clr2_fl", {28'd0, fl}, 32'h0);
    check("clr2_irq_lag", {31'd0, irq}, 32'h1);
    clr = 4'b0000;
    tick();
    check("clr2_irq", {31'd0, irq}, 32'h0);

    // Clear of an already-zero flag is harmless.
    clr = 4'b0010;
    tick();
    clr = 4'b0000;
    check("clr_noop_fl", {28'd0, fl}, 32'h0);

    // Enable gating; held-high source after enabling raises nothing.
    src = 4'b0000; en = 4'b1110;
    tick();
    src = 4'b1001;
    tick();
    check("en_gate_fl", {28'd0, fl}, 32'h8);
    src = 4'b0001; en = 4'hF;
    tick();
    check("held_high_fl", {28'd0, fl}, 32'h8);
    check("held_high_irq", {31'd0, irq}, 32'h1);

    // Mask affects irq only.
    msk = 4'b1000;
    tick();
    check("mask_irq", {31'd0, irq}, 32'h0);
    check("mask_fl", {28'd0, fl}, 32'h8);
    msk = 4'b0000;
    tick();
    check("unmask_irq", {31'd0, irq}, 32'h1);
    clr = 4'b1000;
    tick();
    clr = 4'b0000;
    check("clr3_fl", {28'd0, fl}, 32'h0);
    check("clr3_irq_lag", {31'd0, irq}, 32'h1);
    tick();
    check("clr3_irq", {31'd0, irq}, 32'h0);

    // Event beats simultaneous clear.
    src = 4'b0011;
    tick(); tick();
    check("set1_irq", {31'd0, irq}, 32'h1);
    src = 4'b0001;
    tick();
    src = 4'b0011; clr = 4'b0010;
    tick();
    clr = 4'b0000;
    check("evt_vs_clr_fl", {28'd0, fl}, 32'h2);
    check("evt_vs_clr_irq", {31'd0, irq}, 32'h1);
`ifdef SPI_INT_OVF_EN
    check("evt_vs_clr_ovf", {28'd0, ovf}, 32'h0);
`endif
    tick();
    check("evt_vs_clr_irq2", {31'd0, irq}, 32'h1);

    // Two edges on bit 0 without a clear.
    src = 4'b0010; tick();
    src = 4'b0011; tick();
    check("ovf_first_fl", {28'd0, fl}, 32'h3);
`ifdef SPI_INT_OVF_EN
    check("ovf_first_ovf", {28'd0, ovf}, 32'h0);
`endif
    src = 4'b0010; tick();
    src = 4'b0011; tick();
    check("ovf_second_fl", {28'd0, fl}, 32'h3);
`ifdef SPI_INT_OVF_EN
    check("ovf_second_ovf", {28'd0, ovf}, 32'h1);
`endif
    src = 4'b0010; clr = 4'b0001;
    tick();
    clr = 4'b0000;
    check("ovf_clr_fl", {28'd0, fl}, 32'h2);
`ifdef SPI_INT_OVF_EN
    check("ovf_clr_ovf", {28'd0, ovf}, 32'h0);
`endif

    // Reset mid-operation with all flags set; an edge on the reset cycle is dropped.
    src = 4'b0000; tick();
    src = 4'b1111; tick(); tick();
    check("all_set_fl", {28'd0, fl}, 32'hF);
    check("all_set_irq", {31'd0, irq}, 32'h1);
    src = 4'b0000; tick();
    src = 4'b0001; rst = 1'b1;
    tick();
    check("midrst_fl", {28'd0, fl}, 32'h0);
    check("midrst_irq", {31'd0, irq}, 32'h0);
    rst = 1'b0;
    tick();
    check("post_rst_fl", {28'd0, fl}, 32'h0);
    tick();
    check("post_rst_irq", {31'd0, irq}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
